mem_io_responder: RTL

//   Memory/I-O responder on the CPU byte bus (mem_a/mem_dout/mem_wr/mem_din), opposite end of the cpu initiator.

---
 rtl/mem_io_pkg.sv | 23 ++
 rtl/byte_fifo.sv | 52 +++++
 rtl/mem_io_responder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/mem_io_pkg.sv
// Shared address map and helpers for the CPU-side memory/I-O responder.
package mem_io_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEC_W  = 18;
    localparam int unsigned CNT_W  = 32;

    localparam logic [1:0]       IO_REGION    = 2'b11;
    localparam logic [DEC_W-1:0] IO_DATA_ADDR = 18'h30000;
    localparam logic [DEC_W-1:0] IO_CLK_ADDR  = 18'h30004;

    function automatic logic is_io(input logic [DEC_W-1:0] a);
        return a[DEC_W-1:DEC_W-2] == IO_REGION;
    endfunction

    // Little-endian byte lane of a 32-bit word.
    function automatic logic [DATA_W-1:0] byte_lane(input logic [CNT_W-1:0] w,
                                                    input logic [1:0] lane);
        return DATA_W'(w >> {lane, 3'b000});
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO with wrap-bit pointers; push on full and pop on empty are ignored.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] din_i,
    output logic       full_o,
    output logic       empty_o,
    output logic [7:0] head_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]    mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset; empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU byte-bus responder: RAM, UART RX/TX FIFOs, cycle counter, program-stop flag.
// Optional CYCLE_LATCH_EN: a read of the counter's byte 0 snapshots all 32 bits for coherent reads.
module mem_io_responder
    import mem_io_pkg::*;
#(
    parameter int unsigned RAM_AW   = 17,
    parameter int unsigned RX_DEPTH = 8,
    parameter int unsigned TX_DEPTH = 8
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic [ADDR_W-1:0] mem_a,
    input  logic [DATA_W-1:0] mem_dout,
    input  logic              mem_wr,
    output logic [DATA_W-1:0] mem_din,
    output logic              cpu_rdy_o,
    input  logic [DATA_W-1:0] rx_byte_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic [DATA_W-1:0] tx_byte_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              prog_stop_o,
    output logic              tx_overflow_o
);

    localparam int unsigned RAM_BYTES = 1 << RAM_AW;

    logic [DATA_W-1:0] ram_q [RAM_BYTES];
    logic [DEC_W-1:0]  dec_a;
    logic [RAM_AW-1:0] ram_addr;
    logic              io_sel;
    logic              clk_sel;
    logic              unused_addr;

    logic [DATA_W-1:0] din_q, din_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              stop_q, stop_d;
    logic              ovf_q, ovf_d;
`ifdef CYCLE_LATCH_EN
    logic [CNT_W-1:0]  shadow_q, shadow_d;
`endif

    logic              ram_we;
    logic              rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_head;
    logic              tx_push, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_push_data;

    assign dec_a       = mem_a[DEC_W-1:0];
    assign ram_addr    = mem_a[RAM_AW-1:0];
    assign io_sel      = is_io(dec_a);
    assign clk_sel     = (dec_a[DEC_W-1:2] == IO_CLK_ADDR[DEC_W-1:2]);
    assign unused_addr = ^mem_a[ADDR_W-1:DEC_W];

    assign mem_din       = din_q;
    assign prog_stop_o   = stop_q;
    assign tx_overflow_o = ovf_q;
    assign cpu_rdy_o     = !tx_full;
    assign rx_ready_o    = !rx_full;
    assign tx_valid_o    = !tx_empty;

    // Bus decode: reads load din, writes commit to RAM or I/O side effects.
    always_comb begin
        din_d        = din_q;
        stop_d       = stop_q;
        ovf_d        = ovf_q;
        ram_we       = 1'b0;
        rx_pop       = 1'b0;
        tx_push      = 1'b0;
        tx_push_data = mem_dout;
`ifdef CYCLE_LATCH_EN
        shadow_d     = shadow_q;
`endif
        if (mem_wr) begin
            if (!io_sel) begin
                ram_we = 1'b1;
            end else if (dec_a == IO_DATA_ADDR) begin
                tx_push = (mem_dout != '0);
            end else if (dec_a == IO_CLK_ADDR) begin
                stop_d       = 1'b1;
                tx_push      = 1'b1;
                tx_push_data = '0;
            end
        end else begin
            if (!io_sel) begin
                din_d = ram_q[ram_addr];
            end else if (dec_a == IO_DATA_ADDR) begin
                din_d  = rx_empty ? '0 : rx_head;
                rx_pop = !rx_empty;
            end else if (clk_sel) begin
`ifdef CYCLE_LATCH_EN
                if (dec_a[1:0] == 2'b00) begin
                    shadow_d = cnt_q;
                    din_d    = byte_lane(cnt_q, 2'b00);
                end else begin
                    din_d    = byte_lane(shadow_q, dec_a[1:0]);
                end
`else
                din_d = byte_lane(cnt_q, dec_a[1:0]);
`endif
            end else begin
                din_d = '0;
            end
        end
        if (tx_push && tx_full) ovf_d = 1'b1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            din_q  <= '0;
            cnt_q  <= '0;
            stop_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            din_q  <= din_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            stop_q <= stop_d;
            ovf_q  <= ovf_d;
        end
    end

`ifdef CYCLE_LATCH_EN
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) shadow_q <= '0;
        else           shadow_q <= shadow_d;
    end
`endif

    // RAM contents survive reset.
    always_ff @(posedge clk_in) begin
        if (ram_we) ram_q[ram_addr] <= mem_dout;
    end

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .push_i  (rx_valid_i && !rx_full),
        .pop_i   (rx_pop),
        .din_i   (rx_byte_i),
        .full_o  (rx_full),
        .empty_o (rx_empty),
        .head_o  (rx_head)
    );

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk_i   (clk_in),
        .rst_n_i (rst_n_in),
        .push_i  (tx_push),
        .pop_i   (tx_ready_i && !tx_empty),
        .din_i   (tx_push_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .head_o  (tx_byte_o)
    );

endmodule
